bus_master: RTL and testbench

Single-outstanding bus initiator for the shared tristate memory/peripheral bus. It accepts load/store requests from the CPU core over a valid/ready handshake and drives bus enable, address and read/write control. It drives write data onto the bidirectional data bus and samples read data returned by the addressed responder. It sits between the core's memory stage and the bus, which carries the RAM and I/O devices.

---
 rtl/bus_master_if.sv | 26 ++
 rtl/bus_master.sv | 126 ++++++++++++
 tb/tb_bus_master.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_master_if.sv
// Core-side request/response handshake plus bus control lines for bus_master.
// bus_data is kept off the interface so the tristate resolves on a plain net.
interface bus_master_if #(
  parameter int CPU_WIDTH = 16
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [CPU_WIDTH-1:0] req_addr;
  logic [CPU_WIDTH-1:0] req_wdata;
  logic                 rsp_valid;
  logic [CPU_WIDTH-1:0] rsp_rdata;
  logic                 bus_en;
  logic                 bus_ctrl;
  logic [CPU_WIDTH-1:0] bus_addr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, bus_en, bus_ctrl, bus_addr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, bus_en, bus_ctrl, bus_addr
  );
endinterface

// File: rtl/bus_master.sv
// Single-outstanding initiator: core load/store requests onto the shared tristate bus.
// Store latency 2, load latency RD_WAIT+2; BUS_REQ_BUF_EN adds a one-entry request buffer.
`ifndef IO_CTRL_WRITE
`define IO_CTRL_WRITE 1'b1
`endif
`ifndef IO_CTRL_READ
`define IO_CTRL_READ 1'b0
`endif

module bus_master #(
  parameter int CPU_WIDTH = 16,
  parameter int RD_WAIT   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bus_master_if.master         m_if,
  inout  wire  [CPU_WIDTH-1:0] bus_data
);
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_DONE} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT);

  state_t               r_state;
  state_t               w_next;
  logic [CPU_WIDTH-1:0] r_addr;
  logic [CPU_WIDTH-1:0] r_wdata;
  logic [CPU_WIDTH-1:0] r_rdata;
  logic [3:0]           r_wait;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_launch;
  logic                 w_new_write;
  logic [CPU_WIDTH-1:0] w_new_addr;
  logic [CPU_WIDTH-1:0] w_new_wdata;
  logic                 w_rd_last;
  logic                 w_drive;

`ifdef BUS_REQ_BUF_EN
  logic                 r_buf_vld;
  logic                 r_buf_write;
  logic [CPU_WIDTH-1:0] r_buf_addr;
  logic [CPU_WIDTH-1:0] r_buf_wdata;
  logic                 w_slot;
  logic                 w_buf_load;

  // IDLE and DONE are the only states that can start a transaction next cycle
  assign w_slot      = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_ready     = rst_n && (!r_buf_vld || (r_state == S_DONE));
  assign w_accept    = m_if.req_valid && w_ready;
  assign w_launch    = w_slot && (r_buf_vld || w_accept);
  assign w_buf_load  = w_accept && !(w_slot && !r_buf_vld);
  assign w_new_write = r_buf_vld ? r_buf_write : m_if.req_write;
  assign w_new_addr  = r_buf_vld ? r_buf_addr  : m_if.req_addr;
  assign w_new_wdata = r_buf_vld ? r_buf_wdata : m_if.req_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_vld   <= 1'b0;
      r_buf_write <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_wdata <= '0;
    end else if (w_buf_load) begin
      r_buf_vld   <= 1'b1;
      r_buf_write <= m_if.req_write;
      r_buf_addr  <= m_if.req_addr;
      r_buf_wdata <= m_if.req_wdata;
    end else if (w_launch) begin
      r_buf_vld   <= 1'b0;
    end
  end
`else
  assign w_ready     = rst_n && (r_state == S_IDLE);
  assign w_accept    = m_if.req_valid && w_ready;
  assign w_launch    = w_accept;
  assign w_new_write = m_if.req_write;
  assign w_new_addr  = m_if.req_addr;
  assign w_new_wdata = m_if.req_wdata;
`endif

  assign w_rd_last = (r_state == S_RD) && (r_wait == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: w_next = w_launch ? (w_new_write ? S_WR : S_RD) : S_IDLE;
      S_WR:           w_next = S_DONE;
      S_RD:           w_next = w_rd_last ? S_DONE : S_RD;
      default:        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_wait  <= '0;
    end else begin
      if (w_launch) begin
        r_addr  <= w_new_addr;
        r_wdata <= w_new_wdata;
      end
      if (r_state == S_RD) r_wait <= w_rd_last ? 4'd0 : r_wait + 4'd1;
      else                 r_wait <= 4'd0;
      if (w_rd_last) r_rdata <= bus_data;
    end
  end

  always_comb begin
    m_if.bus_en    = (r_state == S_WR) || (r_state == S_RD);
    m_if.bus_ctrl  = (r_state == S_WR) ? `IO_CTRL_WRITE : `IO_CTRL_READ;
    m_if.rsp_valid = (r_state == S_DONE);
    w_drive        = (r_state == S_WR);
  end

  assign m_if.req_ready = w_ready;
  assign m_if.rsp_rdata = r_rdata;
  assign m_if.bus_addr  = r_addr;
  // State resets asynchronously, so the driver releases the moment rst_n falls
  assign bus_data       = w_drive ? r_wdata : {CPU_WIDTH{1'bz}};
endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master: RAM responder on an RD_WAIT=1 instance, address-pattern ROM on an RD_WAIT=3 instance.
`timescale 1ns/1ps
`ifndef IO_CTRL_WRITE
`define IO_CTRL_WRITE 1'b1
`endif
`ifndef IO_CTRL_READ
`define IO_CTRL_READ 1'b0
`endif

module tb_bus_master;
  localparam int W = 16;
`ifdef BUS_REQ_BUF_EN
  localparam bit BUF_EN = 1'b1;
`else
  localparam bit BUF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_rdata = '0;

  bus_master_if #(.CPU_WIDTH(W)) if0 ();
  bus_master_if #(.CPU_WIDTH(W)) if3 ();
  wire [W-1:0] bd0;
  wire [W-1:0] bd3;

  bus_master #(.CPU_WIDTH(W), .RD_WAIT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .m_if(if0.master), .bus_data(bd0));
  bus_master #(.CPU_WIDTH(W), .RD_WAIT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .m_if(if3.master), .bus_data(bd3));

  // Responders: present junk until RD_WAIT read cycles have elapsed; park 0 when idle
  logic [W-1:0] mem0 [0:255];
  logic [3:0]   rdc0, rdc3;
  logic [W-1:0] tb_val0, tb_val3;

  always @(posedge clk)
    if (rst_n && if0.bus_en && if0.bus_ctrl == `IO_CTRL_WRITE) mem0[if0.bus_addr[7:0]] <= bd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdc0 <= '0;
      rdc3 <= '0;
    end else begin
      rdc0 <= (if0.bus_en && if0.bus_ctrl == `IO_CTRL_READ) ? rdc0 + 4'd1 : 4'd0;
      rdc3 <= (if3.bus_en && if3.bus_ctrl == `IO_CTRL_READ) ? rdc3 + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    tb_val0 = '0;
    tb_val3 = '0;
    if (if0.bus_en) tb_val0 = (rdc0 >= 4'd1) ? mem0[if0.bus_addr[7:0]] : ~mem0[if0.bus_addr[7:0]];
    if (if3.bus_en) tb_val3 = (rdc3 >= 4'd3) ? {if3.bus_addr[7:0] ^ 8'h5A, if3.bus_addr[7:0]}
                                             : 16'hFFFF;
  end

  assign bd0 = (if0.bus_en && if0.bus_ctrl == `IO_CTRL_WRITE) ? {W{1'bz}} : tb_val0;
  assign bd3 = (if3.bus_en && if3.bus_ctrl == `IO_CTRL_WRITE) ? {W{1'bz}} : tb_val3;

  // Scoreboard pop and bus-contention monitor
  always @(negedge clk) begin
    if (rst_n && if0.rsp_valid) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_rsp got rdata=%h, required no response", if0.rsp_rdata);
      end else begin
        logic [W-1:0] e;
        e = sb_q.pop_front();
        if (if0.rsp_rdata !== e) begin
          n_err++;
          $display("FAIL sb_rsp_rdata got %h required %h", if0.rsp_rdata, e);
        end
      end
    end
    if (rst_n && !(if0.bus_en && if0.bus_ctrl == `IO_CTRL_WRITE)) begin
      n_vec++;
      if (bd0 !== tb_val0) begin
        n_err++;
        $display("FAIL bus_release got bus_data=%h required %h (responder only)", bd0, tb_val0);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++; if (if0.req_ready !== 1'b0) begin n_err++; $display("FAIL rst_req_ready got %b required 0", if0.req_ready); end
    n_vec++; if (if0.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid got %b required 0", if0.rsp_valid); end
    n_vec++; if (if0.rsp_rdata !== 16'h0) begin n_err++; $display("FAIL rst_rsp_rdata got %h required 0", if0.rsp_rdata); end
    n_vec++; if (if0.bus_en !== 1'b0) begin n_err++; $display("FAIL rst_bus_en got %b required 0", if0.bus_en); end
    n_vec++; if (if0.bus_ctrl !== `IO_CTRL_READ) begin n_err++; $display("FAIL rst_bus_ctrl got %b required READ", if0.bus_ctrl); end
    n_vec++; if (if0.bus_addr !== 16'h0) begin n_err++; $display("FAIL rst_bus_addr got %h required 0", if0.bus_addr); end
    n_vec++; if (bd0 !== 16'h0) begin n_err++; $display("FAIL rst_bus_data got %h required released", bd0); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (if0.req_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready got %b required 1", if0.req_ready); end
  endtask

  task automatic test_store(input logic [W-1:0] addr, input logic [W-1:0] data);
    @(negedge clk);
    n_vec++; if (if0.req_ready !== 1'b1) begin n_err++; $display("FAIL st_ready got %b required 1", if0.req_ready); end
    if0.req_valid = 1'b1; if0.req_write = 1'b1; if0.req_addr = addr; if0.req_wdata = data;
    sb_q.push_back(exp_rdata);
    @(posedge clk); #1 if0.req_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (if0.bus_en !== 1'b1) begin n_err++; $display("FAIL st_c1_bus_en got %b required 1", if0.bus_en); end
    n_vec++; if (if0.bus_ctrl !== `IO_CTRL_WRITE) begin n_err++; $display("FAIL st_c1_ctrl got %b required WRITE", if0.bus_ctrl); end
    n_vec++; if (if0.bus_addr !== addr) begin n_err++; $display("FAIL st_c1_addr got %h required %h", if0.bus_addr, addr); end
    n_vec++; if (bd0 !== data) begin n_err++; $display("FAIL st_c1_data got %h required %h", bd0, data); end
    @(negedge clk);
    n_vec++; if (if0.rsp_valid !== 1'b1) begin n_err++; $display("FAIL st_c2_rsp_valid got %b required 1", if0.rsp_valid); end
    n_vec++; if (if0.bus_en !== 1'b0) begin n_err++; $display("FAIL st_c2_bus_en got %b required 0", if0.bus_en); end
  endtask

  task automatic test_load(input logic [W-1:0] addr, input logic [W-1:0] data);
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_write = 1'b0; if0.req_addr = addr;
    exp_rdata = data;
    sb_q.push_back(data);
    @(posedge clk); #1 if0.req_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (if0.bus_en !== 1'b1 || if0.bus_ctrl !== `IO_CTRL_READ)
      begin n_err++; $display("FAIL ld_c1_read got en=%b ctrl=%b required en=1 READ", if0.bus_en, if0.bus_ctrl); end
    n_vec++; if (if0.bus_addr !== addr) begin n_err++; $display("FAIL ld_c1_addr got %h required %h", if0.bus_addr, addr); end
    @(negedge clk);
    n_vec++; if (if0.bus_en !== 1'b1 || if0.rsp_valid !== 1'b0)
      begin n_err++; $display("FAIL ld_c2_read got en=%b rsp=%b required en=1 rsp=0", if0.bus_en, if0.rsp_valid); end
    @(negedge clk);
    n_vec++; if (if0.rsp_valid !== 1'b1) begin n_err++; $display("FAIL ld_c3_rsp_valid got %b required 1", if0.rsp_valid); end
    n_vec++; if (if0.rsp_rdata !== data) begin n_err++; $display("FAIL ld_c3_rdata got %h required %h", if0.rsp_rdata, data); end
  endtask

  task automatic test_long_wait();
    int en_cnt = 0;
    int rsp_cyc = 0;
    logic [W-1:0] got = '0;
    @(negedge clk);
    if3.req_valid = 1'b1; if3.req_write = 1'b0; if3.req_addr = 16'h0031;
    @(posedge clk); #1 if3.req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (if3.bus_en) en_cnt++;
      if (if3.rsp_valid && rsp_cyc == 0) begin rsp_cyc = c; got = if3.rsp_rdata; end
    end
    n_vec++; if (en_cnt != 4) begin n_err++; $display("FAIL w3_bus_en_cycles got %0d required 4", en_cnt); end
    n_vec++; if (rsp_cyc != 5) begin n_err++; $display("FAIL w3_rsp_cycle got %0d required 5", rsp_cyc); end
    n_vec++; if (got !== 16'h6B31) begin n_err++; $display("FAIL w3_rdata got %h required 6b31", got); end
  endtask

  task automatic test_back_to_back();
    int n_rsp = 0;
    int ld_cyc = 0;
    logic [W-1:0] ld_dat = '0;
    logic rdy;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_write = 1'b1; if0.req_addr = 16'h0020; if0.req_wdata = 16'hAAAA;
    sb_q.push_back(exp_rdata);
    exp_rdata = 16'hAAAA;
    sb_q.push_back(16'hAAAA);
    @(posedge clk); #1;
    if0.req_write = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      rdy = if0.req_ready;
      if (c == 1) begin
        n_vec++; if (rdy !== BUF_EN) begin n_err++; $display("FAIL b2b_c1_ready got %b required %b", rdy, BUF_EN); end
      end
      if (c == 3) begin
        n_vec++; if (if0.bus_en !== BUF_EN) begin n_err++; $display("FAIL b2b_c3_bus_en got %b required %b", if0.bus_en, BUF_EN); end
      end
      if (c == 4) begin
        n_vec++; if (if0.bus_en !== 1'b1 || if0.bus_ctrl !== `IO_CTRL_READ)
          begin n_err++; $display("FAIL b2b_c4_read got en=%b ctrl=%b required en=1 READ", if0.bus_en, if0.bus_ctrl); end
      end
      if (if0.rsp_valid) begin
        n_rsp++;
        if (n_rsp == 2) begin ld_cyc = c; ld_dat = if0.rsp_rdata; end
      end
      @(posedge clk); #1;
      if (rdy) if0.req_valid = 1'b0;
    end
    n_vec++; if (ld_cyc != (BUF_EN ? 5 : 6))
      begin n_err++; $display("FAIL b2b_load_rsp_cycle got %0d required %0d", ld_cyc, BUF_EN ? 5 : 6); end
    n_vec++; if (ld_dat !== 16'hAAAA) begin n_err++; $display("FAIL b2b_load_rdata got %h required aaaa", ld_dat); end
  endtask

  task automatic test_reset_mid_rd();
    int n_rsp = 0;
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_write = 1'b0; if0.req_addr = 16'h0010;
    @(posedge clk); #1 if0.req_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    n_vec++; if (if0.bus_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_bus_en got %b required 0", if0.bus_en); end
    n_vec++; if (bd0 !== 16'h0) begin n_err++; $display("FAIL mid_rst_bus_data got %h required released", bd0); end
    @(posedge clk); #2 rst_n = 1'b1;
    exp_rdata = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (if0.rsp_valid) n_rsp++;
    end
    n_vec++; if (n_rsp != 0) begin n_err++; $display("FAIL mid_rst_no_rsp got %0d pulses required 0", n_rsp); end
    n_vec++; if (if0.rsp_rdata !== 16'h0) begin n_err++; $display("FAIL mid_rst_rdata got %h required 0", if0.rsp_rdata); end
    test_load(16'h0010, 16'h1234);
  endtask

  initial begin
    if0.req_valid = 1'b0; if0.req_write = 1'b0; if0.req_addr = '0; if0.req_wdata = '0;
    if3.req_valid = 1'b0; if3.req_write = 1'b0; if3.req_addr = '0; if3.req_wdata = '0;
    test_reset();
    test_store(16'h0010, 16'h1234);
    test_load(16'h0010, 16'h1234);
    test_long_wait();
    test_back_to_back();
    repeat (2) @(negedge clk);
    test_reset_mid_rd();
    repeat (3) @(negedge clk);
    n_vec++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_drain got %0d pending required 0", sb_q.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
